apb_sram_ctrl: RTL

//  APB3 slave controller: consumes the request side of the APB SRAM bus and returns
//  the response side (PREADY/PSLVERR/PRDATA), inserting wait states as needed.

---
 rtl/apb_sram_pkg.sv | 17 +
 rtl/sram_sp_mem.sv | 46 ++++
 rtl/apb_sram_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/apb_sram_pkg.sv
// Shared types and constants for the APB-to-SRAM controller and its SRAM macro.
package apb_sram_pkg;

    typedef logic [31:0] apb_addr_t;
    typedef logic [31:0] apb_data_t;

    localparam int unsigned RD_LATENCY_MAX = 4;
    localparam int unsigned ADDR_LSB_DEF   = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } apb_sram_st_e;

endpackage

// File: rtl/sram_sp_mem.sv
// Single-port synchronous SRAM model. Read data can be sampled at the RD_LATENCY-th
// rising edge after the edge that launches i_ce (address is held by the controller).
module sram_sp_mem
    import apb_sram_pkg::*;
#(
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter int unsigned RD_LATENCY = 1,
    localparam int unsigned AW        = $clog2(MEM_DEPTH)
) (
    input  logic            i_clk,
    input  logic            i_ce,
    input  logic            i_we,
    input  logic [AW-1:0]   i_addr,
    input  apb_data_t       i_wdata,
    output apb_data_t       o_rdata
);

    apb_data_t r_mem [MEM_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_ce && i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign o_rdata = r_mem[i_addr];
        end else begin : g_latn
            apb_data_t r_pipe [RD_LATENCY-1];

            // Stage 0 loads on the access edge; later stages just age the word.
            always_ff @(posedge i_clk) begin
                if (i_ce && !i_we) begin
                    r_pipe[0] <= r_mem[i_addr];
                end
                for (int i = 1; i < int'(RD_LATENCY) - 1; i++) begin
                    r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign o_rdata = r_pipe[RD_LATENCY-2];
        end
    endgenerate

endmodule

// File: rtl/apb_sram_ctrl.sv
// APB3 slave that fronts a single-port SRAM: zero-wait writes, RD_LATENCY-wait reads,
// range/alignment errors answered without touching the array.
module apb_sram_ctrl
    import apb_sram_pkg::*;
#(
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned ADDR_LSB   = ADDR_LSB_DEF,
    localparam int unsigned AW        = $clog2(MEM_DEPTH)
) (
    input  logic            PCLK,
    input  logic            PRESET,
    input  apb_addr_t       PADDR,
    input  logic            PSEL,
    input  logic            PENABLE,
    input  logic            PWRITE,
    input  apb_data_t       PWDATA,
    output logic            PREADY,
    output logic            PSLVERR,
    output apb_data_t       PRDATA,
    output logic            sram_ce,
    output logic            sram_we,
    output logic [AW-1:0]   sram_addr,
    output apb_data_t       sram_wdata,
    input  apb_data_t       sram_rdata
);

    localparam int unsigned CNT_W = $clog2(RD_LATENCY_MAX);

    apb_sram_st_e     r_state, w_state_nxt;
    logic             r_pready, w_pready_nxt;
    logic             r_pslverr, w_pslverr_nxt;
    apb_data_t        r_prdata, w_prdata_nxt;
    logic             r_ce, w_ce_nxt;
    logic             r_we, w_we_nxt;
    logic [AW-1:0]    r_addr, w_addr_nxt;
    apb_data_t        r_wdata, w_wdata_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic w_psel, w_penable, w_setup, w_done, w_err;

    // Unknown select/enable must never start or complete a transfer.
    assign w_psel    = (PSEL === 1'b1);
    assign w_penable = (PENABLE === 1'b1);
    assign w_setup   = w_psel && !w_penable;
    assign w_done    = w_psel && w_penable && r_pready;
    assign w_err     = (PADDR[ADDR_LSB-1:0] != '0) ||
                       ((PADDR >> ADDR_LSB) >= apb_addr_t'(MEM_DEPTH));

    always_comb begin
        w_state_nxt   = r_state;
        w_pready_nxt  = r_pready;
        w_pslverr_nxt = r_pslverr;
        w_prdata_nxt  = r_prdata;
        w_ce_nxt      = 1'b0;
        w_we_nxt      = 1'b0;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_cnt_nxt     = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (w_setup) begin
                    w_addr_nxt  = PADDR[ADDR_LSB +: AW];
                    w_wdata_nxt = PWDATA;
                    if (w_err) begin
                        w_state_nxt   = ST_RESP;
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = 1'b1;
                        w_prdata_nxt  = '0;
                    end else if (PWRITE) begin
                        w_state_nxt  = ST_WR;
                        w_ce_nxt     = 1'b1;
                        w_we_nxt     = 1'b1;
                        w_pready_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_RD_WAIT;
                        w_ce_nxt    = 1'b1;
                        w_cnt_nxt   = CNT_W'(RD_LATENCY - 1);
                    end
                end
            end
            ST_RD_WAIT: begin
                // A dropped PSEL wins over data capture so an aborted read leaves PRDATA alone.
                if (!w_psel) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt  = ST_RESP;
                    w_prdata_nxt = sram_rdata;
                    w_pready_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_WR, ST_RESP: begin
                if (!w_psel || w_done) begin
                    w_state_nxt   = ST_IDLE;
                    w_pready_nxt  = 1'b0;
                    w_pslverr_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_pready_nxt  = 1'b0;
                w_pslverr_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state   <= ST_IDLE;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
            r_ce      <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pready  <= w_pready_nxt;
            r_pslverr <= w_pslverr_nxt;
            r_prdata  <= w_prdata_nxt;
            r_ce      <= w_ce_nxt;
            r_we      <= w_we_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign PREADY     = r_pready;
    assign PSLVERR    = r_pslverr;
    assign PRDATA     = r_prdata;
    assign sram_ce    = r_ce;
    assign sram_we    = r_we;
    assign sram_addr  = r_addr;
    assign sram_wdata = r_wdata;

    a_ce_pulse: assert property (@(posedge PCLK) disable iff (PRESET)
        !(sram_ce && $past(sram_ce)));
    a_err_rdy: assert property (@(posedge PCLK) disable iff (PRESET)
        PSLVERR |-> PREADY);
    a_idle_quiet: assert property (@(posedge PCLK) disable iff (PRESET)
        (r_state == ST_IDLE) |-> (!PREADY && !sram_ce));

endmodule
